// File: rtl/ssd_score_display.sv
// Multi-digit seven-segment score display: sequential double-dabble conversion plus digit scan.
// Optional build macro SSD_LZ_BLANK_EN blanks leading zeros.
module ssd_score_display #(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int NUM_AN    = 8,
  parameter int REFRESH_W = 18
) (
  input  logic              board_clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  value,
  input  logic              update,
  output logic [NUM_AN-1:0] an,
  output logic [7:0]        seg,
  output logic              busy,
  output logic              ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic                 pending;
  logic [CNT_W-1:0]     count;
  logic [BIN_W-1:0]     bin_sr;
  logic [BCD_W-1:0]     bcd_sr;
  logic [BCD_W-1:0]     bcd_adj;
  logic                 ovf_int;
  logic [BCD_W-1:0]     digits_q;
  logic [REFRESH_W-1:0] prescaler;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           cur_digit;
  logic                 cur_blank;
  logic [7:0]           seg_next;
`ifdef SSD_LZ_BLANK_EN
  logic [DIGITS-1:0]    lz_mask;
  logic [DIGITS-1:0]    lz_next;
`endif

  function automatic logic [7:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 8'h03;
      4'd1:    encode = 8'h9F;
      4'd2:    encode = 8'h25;
      4'd3:    encode = 8'h0D;
      4'd4:    encode = 8'h99;
      4'd5:    encode = 8'h49;
      4'd6:    encode = 8'h41;
      4'd7:    encode = 8'h1F;
      4'd8:    encode = 8'h01;
      4'd9:    encode = 8'h09;
      default: encode = 8'hFF;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
    end
  end

`ifdef SSD_LZ_BLANK_EN
  // Digit k is a leading zero when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_next  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (bcd_sr[4*k +: 4] == 4'd0);
      lz_next[k] = zero_run & (k != 0);
    end
  end
`endif

  // Control: requests are captured into pending and consumed on the next IDLE cycle.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      digits_q <= '0;
      ovf      <= 1'b0;
`ifdef SSD_LZ_BLANK_EN
      lz_mask  <= '0;
`endif
    end else begin
      pending <= (state == IDLE) ? update : (pending | update);
      case (state)
        IDLE:    if (pending) state <= SHIFT;
        SHIFT:   if (count == CNT_W'(1)) state <= DONE;
        DONE: begin
          digits_q <= bcd_sr;
          ovf      <= ovf_int;
`ifdef SSD_LZ_BLANK_EN
          lz_mask  <= lz_next;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conversion datapath: only meaningful once loaded from IDLE, so it carries no reset.
  always_ff @(posedge board_clk) begin
    if (state == IDLE && pending) begin
      bin_sr  <= value;
      bcd_sr  <= '0;
      ovf_int <= 1'b0;
      count   <= CNT_W'(BIN_W);
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
      ovf_int          <= ovf_int | bcd_adj[BCD_W-1];
      count            <= count - CNT_W'(1);
    end
  end

  assign busy = (state == SHIFT) || (state == DONE);

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = digits_q[4*k +: 4];
`ifdef SSD_LZ_BLANK_EN
        cur_blank = lz_mask[k];
`endif
      end
    end
    seg_next = cur_blank ? 8'hFF : encode(cur_digit);
    if (ovf) seg_next = 8'hFD;
  end

  // Scan: anode and cathode pattern register together so they switch on the same edge.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= '0;
      an        <= '1;
      seg       <= 8'hFF;
    end else begin
      prescaler <= prescaler + REFRESH_W'(1);
      if (&prescaler) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      an        <= ~(NUM_AN'(1) << idx);
      seg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssd_score_display.sv
// Bench for ssd_score_display: vector table, random values against a decimal model, timing corners.
module tb_ssd_score_display;

  localparam int RW = 4;
  localparam logic [7:0] LZ =
`ifdef SSD_LZ_BLANK_EN
    8'hFF;
`else
    8'h03;
`endif

  logic       board_clk = 1'b0;
  logic       reset;
  logic [7:0] value3, value2;
  logic       update3, update2;
  logic [7:0] an3, an2;
  logic [7:0] seg3, seg2;
  logic       busy3, busy2, ovf3, ovf2;

  int errors = 0;
  int checks = 0;

  logic [7:0] enc_tab [10];

  typedef struct {
    int         val;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
  } vec_t;
  vec_t tbl [9];

  ssd_score_display #(.BIN_W(8), .DIGITS(3), .NUM_AN(8), .REFRESH_W(RW)) dut3 (
    .board_clk(board_clk), .reset(reset), .value(value3), .update(update3),
    .an(an3), .seg(seg3), .busy(busy3), .ovf(ovf3));

  ssd_score_display #(.BIN_W(8), .DIGITS(2), .NUM_AN(8), .REFRESH_W(RW)) dut2 (
    .board_clk(board_clk), .reset(reset), .value(value2), .update(update2),
    .an(an2), .seg(seg2), .busy(busy2), .ovf(ovf2));

  always #5 board_clk = ~board_clk;

  function automatic int pow10(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected pattern for position k of an nd-digit display showing val.
  function automatic logic [7:0] model_seg(int val, int nd, int k);
    if (val >= pow10(nd)) return 8'hFD;
`ifdef SSD_LZ_BLANK_EN
    if (k > 0 && val < pow10(k)) return 8'hFF;
`endif
    return enc_tab[(val / pow10(k)) % 10];
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic convert(input int sel, input int val);
    bool_wait: begin
      bit done = 0;
      @(negedge board_clk);
      if (sel == 3) begin value3 = 8'(val); update3 = 1'b1; end
      else          begin value2 = 8'(val); update2 = 1'b1; end
      @(negedge board_clk);
      update3 = 1'b0;
      update2 = 1'b0;
      for (int n = 0; n < 30; n++) begin
        @(negedge board_clk);
        if (n > 0 && !(sel == 3 ? busy3 : busy2)) begin done = 1; break; end
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL convert_timeout: value %0d still busy", val);
      end
    end
  endtask

  task automatic check_pos(input int sel, input int k, input logic [7:0] exp, input string name);
    bit found = 0;
    logic [7:0] want_an;
    want_an = ~(8'h01 << k);
    for (int i = 0; i < 100; i++) begin
      @(negedge board_clk);
      if ((sel == 3 ? an3 : an2) == want_an) begin found = 1; break; end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_scan: anode %h never seen", name, want_an);
    end else begin
      check8(name, (sel == 3 ? seg3 : seg2), exp);
    end
  endtask

  initial begin
    int falls;
    int v;
    logic prev;
    enc_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    tbl[0] = '{173, 8'h0D, 8'h1F, 8'h9F};
    tbl[1] = '{5,   8'h49, LZ,    LZ};
    tbl[2] = '{0,   8'h03, LZ,    LZ};
    tbl[3] = '{255, 8'h49, 8'h49, 8'h25};
    tbl[4] = '{100, 8'h03, 8'h03, 8'h9F};
    tbl[5] = '{42,  8'h25, 8'h99, LZ};
    tbl[6] = '{9,   8'h09, LZ,    LZ};
    tbl[7] = '{78,  8'h01, 8'h1F, LZ};
    tbl[8] = '{64,  8'h99, 8'h41, LZ};

    reset = 1'b1; update3 = 1'b0; update2 = 1'b0; value3 = '0; value2 = '0;
    repeat (3) @(posedge board_clk);
    #1;
    check8("rst_an", an3, 8'hFF);
    check8("rst_seg", seg3, 8'hFF);
    check8("rst_busy", {7'b0, busy3}, 8'h00);
    check8("rst_ovf", {7'b0, ovf3}, 8'h00);
    @(negedge board_clk);
    reset = 1'b0;

    // Scan cadence: each digit held 16 cycles, first anode appears one edge after release.
    for (int n = 1; n <= 52; n++) begin
      @(posedge board_clk);
      #1;
      check8("scan_an3", an3, ~(8'h01 << (((n - 1) / 16) % 3)));
      check8("scan_seg3", seg3, (((n - 1) / 16) % 3 == 0) ? 8'h03 : LZ);
      check8("scan_an2", an2, ~(8'h01 << (((n - 1) / 16) % 2)));
    end

    // Busy window relative to the sampling edge t of update.
    @(negedge board_clk);
    value3 = 8'd173; update3 = 1'b1;
    @(posedge board_clk);
    @(negedge board_clk);
    update3 = 1'b0;
    check8("busy_t0", {7'b0, busy3}, 8'h00);
    for (int j = 1; j <= 10; j++) begin
      @(posedge board_clk);
      #1;
      check8("busy_win", {7'b0, busy3}, (j <= 9) ? 8'h01 : 8'h00);
    end

    for (int i = 0; i < 9; i++) begin
      convert(3, tbl[i].val);
      check_pos(3, 0, tbl[i].s0, "tbl_d0");
      check_pos(3, 1, tbl[i].s1, "tbl_d1");
      check_pos(3, 2, tbl[i].s2, "tbl_d2");
      check8("tbl_ovf", {7'b0, ovf3}, 8'h00);
    end

    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 255));
      convert(3, v);
      for (int k = 0; k < 3; k++) check_pos(3, k, model_seg(v, 3, k), "rnd3");
    end

    convert(2, 255);
    check8("d2_ovf255", {7'b0, ovf2}, 8'h01);
    check_pos(2, 0, 8'hFD, "d2_dash0");
    check_pos(2, 1, 8'hFD, "d2_dash1");
    convert(2, 42);
    check8("d2_ovf42", {7'b0, ovf2}, 8'h00);
    check_pos(2, 0, 8'h25, "d2_42_d0");
    check_pos(2, 1, 8'h99, "d2_42_d1");
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 99 : (i == 1) ? 100 : int'($urandom_range(0, 255));
      convert(2, v);
      check8("rnd2_ovf", {7'b0, ovf2}, (v >= 100) ? 8'h01 : 8'h00);
      for (int k = 0; k < 2; k++) check_pos(2, k, model_seg(v, 2, k), "rnd2");
    end

    // Request during busy collapses into exactly one follow-up conversion of the new value.
    @(negedge board_clk);
    value3 = 8'd10; update3 = 1'b1;
    @(negedge board_clk);
    update3 = 1'b0;
    repeat (3) @(negedge board_clk);
    value3 = 8'd11; update3 = 1'b1;
    @(negedge board_clk);
    update3 = 1'b0;
    @(negedge board_clk);
    update3 = 1'b1;
    @(negedge board_clk);
    update3 = 1'b0;
    falls = 0;
    prev = busy3;
    for (int n = 0; n < 60; n++) begin
      @(negedge board_clk);
      if (prev && !busy3) falls++;
      prev = busy3;
    end
    check8("pend_convs", 8'(falls), 8'd2);
    check8("pend_idle", {7'b0, busy3}, 8'h00);
    check_pos(3, 0, 8'h9F, "pend_d0");
    check_pos(3, 1, 8'h9F, "pend_d1");
    check_pos(3, 2, LZ, "pend_d2");

    // Asynchronous reset in the middle of a conversion.
    @(negedge board_clk);
    value3 = 8'd200; update3 = 1'b1;
    @(negedge board_clk);
    update3 = 1'b0;
    repeat (3) @(negedge board_clk);
    check8("pre_rst_busy", {7'b0, busy3}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check8("arst_an", an3, 8'hFF);
    check8("arst_seg", seg3, 8'hFF);
    check8("arst_busy", {7'b0, busy3}, 8'h00);
    check8("arst_an2", an2, 8'hFF);
    check8("arst_ovf2", {7'b0, ovf2}, 8'h00);
    @(negedge board_clk);
    reset = 1'b0;
    falls = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge board_clk);
      if (busy3) falls++;
    end
    check8("post_rst_nobusy", 8'(falls), 8'd0);
    check_pos(3, 0, 8'h03, "post_rst_d0");
    check_pos(3, 1, LZ, "post_rst_d1");
    check_pos(3, 2, LZ, "post_rst_d2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
